// File: rtl/mem_stage.sv
// MEM pipeline stage: issues single-beat data-bus accesses with req/ack, stalls
// the pipeline until completion, aligns load data and tracks the LL/SC link bit.
package mem_stage_pkg;
  localparam int N_REG      = 32;
  localparam int N_REG_ADDR = 5;
  localparam int N_ALU_OP   = 8;
  localparam int N_MEM_ADDR = 32;
  localparam int N_MEM_DATA = 32;

  localparam logic [N_ALU_OP-1:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [N_ALU_OP-1:0] EXE_OR_OP  = 8'b0010_0101;
  localparam logic [N_ALU_OP-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [N_ALU_OP-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [N_ALU_OP-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [N_ALU_OP-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [N_ALU_OP-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [N_ALU_OP-1:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [N_ALU_OP-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [N_ALU_OP-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [N_ALU_OP-1:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [N_ALU_OP-1:0] EXE_SC_OP  = 8'b1111_1000;

  localparam logic NO_STOP = 1'b0;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wen,
  input  logic [N_REG-1:0]      i_wdata,
  input  logic [N_REG_ADDR-1:0] i_waddr,
  input  logic                  i_hilo_wen,
  input  logic [N_REG-1:0]      i_hi,
  input  logic [N_REG-1:0]      i_lo,
  input  logic [N_ALU_OP-1:0]   i_aluop,
  input  logic [N_MEM_ADDR-1:0] i_addr,
  input  logic [N_MEM_DATA-1:0] i_data,
  input  logic [5:0]            i_stall,
  input  logic                  i_flush,
  output logic                  o_wen,
  output logic [N_REG-1:0]      o_wdata,
  output logic [N_REG_ADDR-1:0] o_waddr,
  output logic                  o_hilo_wen,
  output logic [N_REG-1:0]      o_hi,
  output logic [N_REG-1:0]      o_lo,
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [N_MEM_ADDR-1:0] o_bus_addr,
  output logic [3:0]            o_bus_sel,
  output logic [N_MEM_DATA-1:0] o_bus_wdata,
  input  logic                  i_bus_ack,
  input  logic [N_MEM_DATA-1:0] i_bus_rdata,
  output logic                  o_stallreq,
  output logic                  o_llbit
);

  typedef enum logic {IDLE, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t                state_q, state_d;
  logic                  llbit_q, llbit_d;
  logic [N_MEM_DATA-1:0] rdata_q, rdata_d;

  logic  is_load, is_store, is_ll, is_sc, is_signed, access;
  size_t size;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [N_REG-1:0]      load_data;

  logic unused_stall;
  assign unused_stall = &{1'b0, i_stall[5], i_stall[3:0]};

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_ll     = 1'b0;
    is_sc     = 1'b0;
    is_signed = 1'b0;
    size      = SZ_WORD;
    case (i_aluop)
      EXE_LB_OP:  begin is_load = 1'b1; size = SZ_BYTE; is_signed = 1'b1; end
      EXE_LBU_OP: begin is_load = 1'b1; size = SZ_BYTE; end
      EXE_LH_OP:  begin is_load = 1'b1; size = SZ_HALF; is_signed = 1'b1; end
      EXE_LHU_OP: begin is_load = 1'b1; size = SZ_HALF; end
      EXE_LW_OP:  is_load = 1'b1;
      EXE_LL_OP:  begin is_load = 1'b1; is_ll = 1'b1; end
      EXE_SB_OP:  begin is_store = 1'b1; size = SZ_BYTE; end
      EXE_SH_OP:  begin is_store = 1'b1; size = SZ_HALF; end
      EXE_SW_OP:  is_store = 1'b1;
      EXE_SC_OP:  begin is_store = 1'b1; is_sc = 1'b1; end
      default:    ;
    endcase
  end

  // A failing SC (no link) never touches the bus.
  assign access = (is_load || is_store) && !(is_sc && !llbit_q);

  // Big-endian lane mapping: address 0 is the most significant byte.
  always_comb begin
    o_bus_sel   = 4'b1111;
    o_bus_wdata = i_data;
    case (size)
      SZ_BYTE: begin
        o_bus_sel   = 4'b1000 >> i_addr[1:0];
        o_bus_wdata = {4{i_data[7:0]}};
      end
      SZ_HALF: begin
        o_bus_sel   = i_addr[1] ? 4'b0011 : 4'b1100;
        o_bus_wdata = {2{i_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign o_bus_we   = is_store;
  assign o_bus_addr = {i_addr[31:2], 2'b00};

  always_comb begin
    lane_b    = rdata_q[31:24];
    lane_h    = i_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    load_data = rdata_q;
    case (i_addr[1:0])
      2'b01:   lane_b = rdata_q[23:16];
      2'b10:   lane_b = rdata_q[15:8];
      2'b11:   lane_b = rdata_q[7:0];
      default: lane_b = rdata_q[31:24];
    endcase
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{is_signed & lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    llbit_d    = llbit_q;
    rdata_d    = rdata_q;
    o_bus_req  = 1'b0;
    o_stallreq = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so an access in flight drops the request immediately.
        o_stallreq = access && i_rst_n;
        o_bus_req  = access && i_rst_n && !i_flush;
        if (access && i_bus_ack && !i_flush) begin
          state_d = DONE;
          rdata_d = i_bus_rdata;
          if (is_ll) llbit_d = 1'b1;
          if (is_sc) llbit_d = 1'b0;
        end
      end
      DONE: begin
        if (i_stall[4] == NO_STOP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) begin
      state_d = IDLE;
      llbit_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      llbit_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      llbit_q <= llbit_d;
      rdata_q <= rdata_d;
    end
  end

  // SC result: link still held while pending, or success already recorded in DONE.
  always_comb begin
    if (is_sc)        o_wdata = {31'b0, (state_q == DONE) || llbit_q};
    else if (is_load) o_wdata = load_data;
    else              o_wdata = i_wdata;
  end

  assign o_wen      = is_sc ? 1'b1 : i_wen;
  assign o_waddr    = i_waddr;
  assign o_hilo_wen = i_hilo_wen;
  assign o_hi       = i_hi;
  assign o_lo       = i_lo;
  assign o_llbit    = llbit_q;

endmodule
